// File: rtl/mem_unit_wbuf.sv
// mem_unit_wbuf: writable PM plus DM behind a delayed-commit write pipeline with read bypass
module mem_unit_wbuf #(
    parameter int PMA_SIZE = 8,
    parameter int PMD_SIZE = 32,
    parameter int DMA_SIZE = 8,
    parameter int DMD_SIZE = 16,
    parameter int WB_DEPTH = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                ps_pm_cslt,
    input  logic                ps_pm_wrb,
    input  logic [PMA_SIZE-1:0] ps_pm_add,
    input  logic [PMD_SIZE-1:0] ps_pm_wdt,
    output logic [PMD_SIZE-1:0] pm_ps_op,
    input  logic                ps_dm_cslt,
    input  logic                ps_dm_wrb,
    input  logic [DMA_SIZE-1:0] dg_dm_add,
    input  logic [DMD_SIZE-1:0] bc_dt,
    output logic [DMD_SIZE-1:0] dm_bc_dt,
    output logic                dm_rd_vld,
    output logic [2:0]          dm_wb_cnt
);
    logic [PMD_SIZE-1:0] r_pm [2**PMA_SIZE];
    logic [DMD_SIZE-1:0] r_dm [2**DMA_SIZE];
    logic [WB_DEPTH-1:0] r_v;
    logic [DMA_SIZE-1:0] r_a [WB_DEPTH];
    logic [DMD_SIZE-1:0] r_d [WB_DEPTH];
    logic                w_pm_wr;
    logic                w_pm_rd;
    logic                w_dm_wr;
    logic                w_dm_rd;
    logic [DMD_SIZE-1:0] w_rd_dt;
    logic [2:0]          w_cnt_nxt;

    assign w_pm_wr = reset && ps_pm_cslt && ps_pm_wrb;
    assign w_pm_rd = ps_pm_cslt && !ps_pm_wrb;
    assign w_dm_wr = ps_dm_cslt && ps_dm_wrb;
    assign w_dm_rd = ps_dm_cslt && !ps_dm_wrb;

    // PM array write port; gated by reset so a write during reset is dropped
    always_ff @(posedge clk) begin
        if (w_pm_wr)
            r_pm[ps_pm_add] <= ps_pm_wdt;
    end

    // PM registered read data
    always_ff @(posedge clk) begin
        if (!reset)
            pm_ps_op <= '0;
        else if (w_pm_rd)
            pm_ps_op <= r_pm[ps_pm_add];
    end

    // write pipeline valid bits: S0 takes the new request, older stages shift down
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_v <= '0;
        end else begin
            r_v[0] <= w_dm_wr;
            for (int k = 1; k < WB_DEPTH; k++)
                r_v[k] <= r_v[k-1];
        end
    end

    // write pipeline payload; qualified by the valid bits so it needs no reset
    always_ff @(posedge clk) begin
        r_a[0] <= dg_dm_add;
        r_d[0] <= bc_dt;
        for (int k = 1; k < WB_DEPTH; k++) begin
            r_a[k] <= r_a[k-1];
            r_d[k] <= r_d[k-1];
        end
    end

    // commit the final stage into the DM array; reset discards it
    always_ff @(posedge clk) begin
        if (reset && r_v[WB_DEPTH-1])
            r_dm[r_a[WB_DEPTH-1]] <= r_d[WB_DEPTH-1];
    end

    // read source: youngest matching pending write, else the array
    always_comb begin
        w_rd_dt = r_dm[dg_dm_add];
        for (int k = WB_DEPTH - 1; k >= 0; k--)
            if (r_v[k] && r_a[k] == dg_dm_add)
                w_rd_dt = r_d[k];
    end

    // number of stages that will be valid after the next edge
    always_comb begin
        w_cnt_nxt = {2'b0, w_dm_wr};
        for (int k = 0; k < WB_DEPTH - 1; k++)
            w_cnt_nxt = w_cnt_nxt + {2'b0, r_v[k]};
    end

    // DM registered read data, read strobe and pending-write count
    always_ff @(posedge clk) begin
        if (!reset) begin
            dm_bc_dt  <= '0;
            dm_rd_vld <= 1'b0;
            dm_wb_cnt <= '0;
        end else begin
            dm_rd_vld <= w_dm_rd;
            dm_wb_cnt <= w_cnt_nxt;
            if (w_dm_rd)
                dm_bc_dt <= w_rd_dt;
        end
    end
endmodule
